// File: rtl/memctrl_nport_if.sv
// Client request/response and byte-wide RAM/IO bus bundle for memctrl_nport.
interface memctrl_nport_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_wr;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*32-1:0]         req_data;
  logic [NUM_PORTS*3-1:0]          req_len;
  logic [NUM_PORTS-1:0]            resp_done;
  logic [31:0]                     resp_data;
  logic                            busy;
  logic                            io_buffer_full;
  logic [7:0]                      ram_din;
  logic [7:0]                      ram_dout;
  logic [ADDR_WIDTH-1:0]           ram_a;
  logic                            ram_wr;

  // Clients plus the RAM/IO side, as seen from outside the controller.
  modport master (
    output req_valid, req_wr, req_addr, req_data, req_len, io_buffer_full, ram_din,
    input  resp_done, resp_data, busy, ram_dout, ram_a, ram_wr
  );

  // The controller itself.
  modport slave (
    input  req_valid, req_wr, req_addr, req_data, req_len, io_buffer_full, ram_din,
    output resp_done, resp_data, busy, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/memctrl_nport.sv
// N-port arbiter for a byte-wide RAM/IO bus; 1-4 byte little-endian transfers.
module memctrl_nport #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter bit          RR_MODE    = 1'b1
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           rdy_in,
  memctrl_nport_if.slave bus
);
  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned EXT_W = (ADDR_WIDTH > 18) ? ADDR_WIDTH : 18;
  localparam int unsigned LEN_W = 3;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      ptr, gnt, win_idx, hi_idx, lo_idx;
  logic                  hi_found, lo_found;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_data;
  logic [LEN_W-1:0]      sel_len;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      cnt;
  logic [31:0]           cap;
  logic                  load, adv, capture;
  logic [LEN_W-1:0]      rd_idx;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [1:0]            io_bits;
  logic                  io_stall;

  // Winner search: first valid above the pointer, else lowest valid (wraps).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (bus.req_valid[i]) begin
        if (RR_MODE && (32'(ptr) < i) && !hi_found) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(i);
        end
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = PTR_W'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  // Mux the winning port's request fields.
  always_comb begin
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_len  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (PTR_W'(i) == win_idx) begin
        sel_wr   = bus.req_wr[i];
        sel_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = bus.req_data[i*32 +: 32];
        sel_len  = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Byte addresses; while frozen (or on the final capture cycle) a read keeps
  // presenting the byte whose data is still outstanding so it is re-captured.
  always_comb begin
    rd_idx = cnt;
    if ((cnt != '0) && (!rdy_in || (cnt == len_q))) rd_idx = cnt - LEN_W'(1);
    rd_addr  = addr_q + ADDR_WIDTH'(rd_idx);
    wr_addr  = addr_q + ADDR_WIDTH'(cnt);
    io_bits  = 2'(EXT_W'(wr_addr) >> 16);
    io_stall = (io_bits == 2'b11) && bus.io_buffer_full;
  end

  // Next state and datapath strobes; nothing moves while rdy_in is low.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    capture   = 1'b0;
    if (rdy_in) begin
      unique case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            load      = 1'b1;
            state_nxt = (sel_len == '0) ? DONE : (sel_wr ? WR : RD);
          end
        end
        RD: begin
          adv     = (cnt != len_q);
          capture = (cnt != '0);
          if (cnt == len_q) state_nxt = DONE;
        end
        WR: begin
          if (!io_stall) begin
            adv = 1'b1;
            if (cnt == len_q - LEN_W'(1)) state_nxt = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // Request latch, byte counter, capture register and round-robin pointer.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr    <= PTR_W'(NUM_PORTS - 1);
      gnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
      cap    <= '0;
    end else begin
      if (load) begin
        gnt    <= win_idx;
        if (RR_MODE) ptr <= win_idx;
        addr_q <= sel_addr;
        data_q <= sel_data;
        len_q  <= (sel_len > LEN_W'(4)) ? LEN_W'(4) : sel_len;
        cnt    <= '0;
        cap    <= '0;
      end
      if (adv) cnt <= cnt + LEN_W'(1);
      for (int unsigned k = 0; k < 4; k++) begin
        if (capture && (cnt == LEN_W'(k + 1))) cap[8*k +: 8] <= bus.ram_din;
      end
    end
  end

  // Bus and response outputs decoded from the registered state.
  always_comb begin
    bus.ram_a     = '0;
    bus.ram_dout  = '0;
    bus.ram_wr    = 1'b0;
    bus.resp_data = '0;
    bus.busy      = (state != IDLE);
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      bus.resp_done[i] = (state == DONE) && rdy_in && (PTR_W'(i) == gnt);
    end
    unique case (state)
      RD: bus.ram_a = rd_addr;
      WR: begin
        bus.ram_a    = wr_addr;
        bus.ram_dout = 8'(data_q >> {cnt, 3'b000});
        bus.ram_wr   = rdy_in && !io_stall;
      end
      DONE:    bus.resp_data = cap;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_memctrl_nport.sv
// Randomized bench for memctrl_nport against a transaction-level memory model.
module tb_memctrl_nport;
  localparam int unsigned NP = 3;
  localparam int unsigned AW = 32;

  logic clk;
  logic rst_n;
  logic rdy;

  memctrl_nport_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) bus ();
  memctrl_nport_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) bus_fp ();

  memctrl_nport #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .RR_MODE(1'b1)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .bus(bus.slave));

  memctrl_nport #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .RR_MODE(1'b0)) dut_fp (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .bus(bus_fp.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int frz_bad;
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] wl_a[$];
  logic [7:0]  wl_d[$];
  logic [31:0] rec_a [64];
  logic        rec_wr [64];
  logic [7:0]  rec_dout [64];
  int          got_order [8];

  // Sparse RAM: written bytes are remembered, everything else is a fixed hash.
  function automatic logic [7:0] memval(input logic [31:0] a);
    logic [31:0] h;
    if (mem.exists(a)) return mem[a];
    h = a * 32'h9E37_79B1;
    return h[31:24];
  endfunction

  // RAM returns the addressed byte one cycle later.
  always @(posedge clk) bus.ram_din <= memval(bus.ram_a);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input bit v, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] len);
    bus.req_valid[p]          = v;
    bus.req_wr[p]             = wr;
    bus.req_addr[p*AW +: AW]  = a;
    bus.req_data[p*32 +: 32]  = d;
    bus.req_len[p*3 +: 3]     = len;
  endtask

  // One request on one port; records the bus per cycle (cycle 0 = request seen).
  task automatic txn(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] len, input int full_n, input int gap_at, input int gap_n,
                     output int done_c, output logic [31:0] rdata);
    wl_a.delete();
    wl_d.delete();
    for (int i = 0; i < 64; i++) begin
      rec_a[i] = '0; rec_wr[i] = 1'b0; rec_dout[i] = '0;
    end
    done_c = -1;
    rdata  = '0;
    @(posedge clk); #1;
    set_req(p, 1'b1, wr, a, d, len);
    for (int c = 0; c < 60 && done_c < 0; c++) begin
      bus.io_buffer_full = (c >= 1 && c <= full_n);
      rdy = !(gap_n > 0 && c >= gap_at && c < gap_at + gap_n);
      @(negedge clk);
      rec_a[c]    = bus.ram_a;
      rec_wr[c]   = bus.ram_wr;
      rec_dout[c] = bus.ram_dout;
      if (bus.ram_wr) begin
        wl_a.push_back(bus.ram_a);
        wl_d.push_back(bus.ram_dout);
        mem[bus.ram_a] = bus.ram_dout;
        if (!rdy) frz_bad++;
      end
      if (bus.resp_done != '0) begin
        done_c = c;
        rdata  = bus.resp_data;
        check("done_port", 64'(bus.resp_done), 64'(1 << p));
      end
      @(posedge clk); #1;
    end
    bus.req_valid[p]   = 1'b0;
    bus.io_buffer_full = 1'b0;
    rdy                = 1'b1;
    if (done_c < 0) check("txn_timeout", 0, 1);
  endtask

  // Expected outcome derived from the transfer rules, then compared.
  task automatic run_check(input string tag, input int p, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] len, input int full_n,
                           input int gap_at_in, input int gap_n);
    int L, nominal, exp_done, gap_at, done_c;
    logic [31:0] exp_data, rdata;
    bit io;
    L = (len > 3'd4) ? 4 : int'(len);
    exp_data = '0;
    if (!wr) for (int k = 0; k < L; k++) exp_data[8*k +: 8] = memval(a + 32'(k));
    nominal  = (L == 0) ? 1 : (wr ? L + 1 : L + 2);
    io       = wr && (L > 0) && (a[17:16] == 2'b11);
    gap_at   = (gap_n > 0 && gap_at_in <= 0) ? int'($urandom_range(1, nominal)) : gap_at_in;
    exp_done = nominal + (io ? full_n : 0) + (gap_n > 0 ? gap_n : 0);
    txn(p, wr, a, d, len, full_n, gap_at, gap_n, done_c, rdata);
    check({tag, "_latency"}, 64'(done_c), 64'(exp_done));
    check({tag, "_data"}, 64'(rdata), 64'(exp_data));
    check({tag, "_nwrites"}, 64'(wl_a.size()), 64'(wr ? L : 0));
    for (int k = 0; k < wl_a.size() && k < L; k++) begin
      check({tag, "_waddr"}, 64'(wl_a[k]), 64'(a + 32'(k)));
      check({tag, "_wbyte"}, 64'(wl_d[k]), 64'(d[8*k +: 8]));
    end
  endtask

  // Collect n grant pulses from one DUT; optionally drop the winner's request.
  task automatic watch_grants(input bit sel, input int n, input bit drop);
    int got;
    logic [NP-1:0] rd;
    got = 0;
    for (int c = 0; c < 40 * n && got < n; c++) begin
      @(negedge clk);
      rd = sel ? bus_fp.resp_done : bus.resp_done;
      if (rd != '0) begin
        check("grant_onehot", 64'($countones(rd)), 64'd1);
        for (int i = 0; i < NP; i++) if (rd[i]) got_order[got] = i;
        got++;
      end
      @(posedge clk); #1;
      if (drop) for (int i = 0; i < NP; i++) if (rd[i]) bus.req_valid[i] = 1'b0;
    end
    if (got < n) check("grant_timeout", 64'(got), 64'(n));
  endtask

  initial begin
    int mptr;
    int p, full_n, gap_n;
    bit wr;
    logic [31:0] a;
    logic [2:0] len;
    n_tests = 0; n_fail = 0; frz_bad = 0;
    rst_n = 1'b0; rdy = 1'b1;
    bus.req_valid = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_data = '0; bus.req_len = '0;
    bus.io_buffer_full = 1'b0;
    bus_fp.req_valid = '0; bus_fp.req_wr = '0; bus_fp.req_addr = '0; bus_fp.req_data = '0;
    bus_fp.req_len = '0; bus_fp.io_buffer_full = 1'b0; bus_fp.ram_din = '0;
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;

    #12;
    check("reset_outputs", {bus.busy, bus.ram_wr, bus.ram_a, bus.ram_dout, bus.resp_done}, 0);
    check("reset_resp_data", 64'(bus.resp_data), 0);
    @(negedge clk); rst_n = 1'b1;

    // Round-robin with all ports requesting continuously.
    @(posedge clk); #1;
    for (int i = 0; i < NP; i++) set_req(i, 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
    watch_grants(1'b0, 4, 1'b0);
    bus.req_valid = '0;
    mptr = NP - 1;
    for (int i = 0; i < 4; i++) begin
      mptr = (mptr + 1) % NP;
      check("rr_order", 64'(got_order[i]), 64'(mptr));
    end

    // Fixed priority: lowest index keeps winning until it lets go.
    bus_fp.req_valid = '1;
    watch_grants(1'b1, 4, 1'b0);
    for (int i = 0; i < 4; i++) check("fp_order", 64'(got_order[i]), 64'd0);
    bus_fp.req_valid[0] = 1'b0;
    watch_grants(1'b1, 1, 1'b0);
    check("fp_next", 64'(got_order[0]), 64'd1);
    bus_fp.req_valid = '0;

    // Directed transfers.
    run_check("rd4", 0, 1'b0, 32'h100, 32'h0, 3'd4, 0, 0, 0);
    for (int k = 1; k <= 4; k++) check("rd4_addr", 64'(rec_a[k]), 64'(32'h100 + 32'(k - 1)));
    check("rd4_nowr", 64'({rec_wr[1], rec_wr[2], rec_wr[3], rec_wr[4]}), 0);
    run_check("wr2", 1, 1'b1, 32'h200, 32'hAABBCCDD, 3'd2, 0, 0, 0);
    check("wr2_c1", {rec_a[1], rec_dout[1], 7'd0, rec_wr[1]}, {32'h200, 8'hDD, 8'h01});
    check("wr2_c2", {rec_a[2], rec_dout[2], 7'd0, rec_wr[2]}, {32'h201, 8'hCC, 8'h01});
    run_check("io_stall", 0, 1'b1, 32'h0003_0000, 32'h5A, 3'd1, 3, 0, 0);
    check("io_held", 64'({rec_wr[1], rec_wr[2], rec_wr[3]}), 0);
    check("io_write", 64'(rec_wr[4]), 64'd1);
    run_check("io_none", 0, 1'b1, 32'h0000_0400, 32'h77, 3'd1, 3, 0, 0);
    run_check("rd_gap", 2, 1'b0, 32'h1234, 32'h0, 3'd2, 0, 2, 2);
    run_check("clamp", 1, 1'b0, 32'h100, 32'h0, 3'd7, 0, 0, 0);
    run_check("len0", 0, 1'b1, 32'h200, 32'hFFFF_FFFF, 3'd0, 0, 0, 0);
    run_check("wrap", 2, 1'b0, 32'hFFFF_FFFE, 32'h0, 3'd4, 0, 0, 0);
    run_check("readback", 1, 1'b0, 32'h200, 32'h0, 3'd3, 0, 0, 0);

    // Randomized transfers.
    for (int t = 0; t < 40; t++) begin
      p   = int'($urandom_range(0, NP - 1));
      wr  = 1'($urandom_range(0, 1));
      len = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       a = 32'h0003_0000 | 32'($urandom_range(0, 250));
        1:       a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
        default: a = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 251));
      endcase
      full_n = (wr && a[31:16] == 16'h0003) ? int'($urandom_range(0, 3)) : 0;
      gap_n  = (full_n == 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_check($sformatf("rnd%0d", t), p, wr, a, $urandom, len, full_n, 0, gap_n);
    end

    // Asynchronous reset mid-write, then pointer restart favours port 0.
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 32'h500, 32'h01020304, 3'd4);
    repeat (3) @(posedge clk);
    #2;
    set_req(1, 1'b1, 1'b0, 32'h600, 32'h0, 3'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async", {bus.busy, bus.ram_wr, bus.ram_a, bus.ram_dout, bus.resp_done}, 0);
    @(negedge clk); rst_n = 1'b1;
    watch_grants(1'b0, 2, 1'b1);
    check("rst_first", 64'(got_order[0]), 64'd0);
    check("rst_second", 64'(got_order[1]), 64'd1);
    bus.req_valid = '0;

    check("no_wr_frozen", 64'(frz_bad), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
